// File: rtl/stream_fifo_clearable_pkg.sv
// Shared types and helpers for the clearable multi-channel stream FIFO.
package stream_fifo_clearable_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIsolate,
    StFlush
  } clr_state_e;

  function automatic int unsigned usage_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stream_fifo_clearable_chan.sv
// One FIFO channel: storage, pointers, fill count and the isolate/flush clear sequencer.
module stream_fifo_clearable_chan
  import stream_fifo_clearable_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CLEAR_CYCLES = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  output logic                          clear_pending_o,
  input  logic [DATA_WIDTH-1:0]         src_data_i,
  input  logic                          src_valid_i,
  output logic                          src_ready_o,
  output logic [DATA_WIDTH-1:0]         dst_data_o,
  output logic                          dst_valid_o,
  input  logic                          dst_ready_i,
  output logic [usage_width(DEPTH)-1:0] usage_o
);

  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned UsageW = usage_width(DEPTH);
  localparam int unsigned FlushW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  localparam logic [PtrW-1:0]   LastPtr   = PtrW'(DEPTH - 1);
  localparam logic [UsageW-1:0] FullCount = UsageW'(DEPTH);
  localparam logic [FlushW-1:0] FlushLoad = FlushW'(CLEAR_CYCLES - 1);

  clr_state_e        state_q, state_d;
  logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;
  logic              clear_pending_q;

  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [UsageW-1:0]     count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic push, pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      flush_cnt_q     <= '0;
      clear_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_cnt_q     <= flush_cnt_d;
      clear_pending_q <= (state_d != StIdle);
    end
  end

  // Requests arriving outside StIdle are dropped; a held level re-arms on return.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clear_i) state_d = StIsolate;
      end
      StIsolate: begin
        state_d     = StFlush;
        flush_cnt_d = FlushLoad;
      end
      StFlush: begin
        if (flush_cnt_q == '0) state_d = StIdle;
        else                   flush_cnt_d = flush_cnt_q - FlushW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    src_ready_o = (state_q == StIdle) && (count_q < FullCount);
    dst_valid_o = (state_q == StIdle) && (count_q != '0);
  end

  assign clear_pending_o = clear_pending_q;
  assign usage_o         = count_q;
  assign dst_data_o      = mem_q[rd_ptr_q];

  assign push = src_valid_i & src_ready_o;
  assign pop  = dst_valid_o & dst_ready_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (state_q == StFlush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_d = count_q + UsageW'(1);
      else if (pop && !push) count_d = count_q - UsageW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset; only the pointers define its contents.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= src_data_i;
  end

endmodule

// File: rtl/stream_fifo_clearable_mc.sv
// Multi-channel stream FIFO with per-channel sequenced clear; channels are fully independent.
module stream_fifo_clearable_mc
  import stream_fifo_clearable_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned CLEAR_CYCLES = 1
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [NUM_CHANNELS-1:0]                    clear_i,
  output logic [NUM_CHANNELS-1:0]                    clear_pending_o,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]         src_data_i,
  input  logic [NUM_CHANNELS-1:0]                    src_valid_i,
  output logic [NUM_CHANNELS-1:0]                    src_ready_o,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]         dst_data_o,
  output logic [NUM_CHANNELS-1:0]                    dst_valid_o,
  input  logic [NUM_CHANNELS-1:0]                    dst_ready_i,
  output logic [NUM_CHANNELS*usage_width(DEPTH)-1:0] usage_o
);

  localparam int unsigned UsageW = usage_width(DEPTH);

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    stream_fifo_clearable_chan #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DEPTH       (DEPTH),
      .CLEAR_CYCLES(CLEAR_CYCLES)
    ) u_chan (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .clear_i        (clear_i[c]),
      .clear_pending_o(clear_pending_o[c]),
      .src_data_i     (src_data_i[c*DATA_WIDTH +: DATA_WIDTH]),
      .src_valid_i    (src_valid_i[c]),
      .src_ready_o    (src_ready_o[c]),
      .dst_data_o     (dst_data_o[c*DATA_WIDTH +: DATA_WIDTH]),
      .dst_valid_o    (dst_valid_o[c]),
      .dst_ready_i    (dst_ready_i[c]),
      .usage_o        (usage_o[c*UsageW +: UsageW])
    );
  end

endmodule

// File: tb/tb_stream_fifo_clearable_mc.sv
// Bench: two-channel DEPTH=4/CLEAR_CYCLES=2 instance plus a DEPTH=3 single-channel instance.
module tb_stream_fifo_clearable_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  clear_a, pend_a, src_valid_a, src_ready_a, dst_valid_a, dst_ready_a;
  logic [63:0] src_data_a, dst_data_a;
  logic [5:0]  usage_a;
  logic [0:0]  clear_b, pend_b, src_valid_b, src_ready_b, dst_valid_b, dst_ready_b;
  logic [31:0] src_data_b, dst_data_b;
  logic [1:0]  usage_b;

  stream_fifo_clearable_mc #(
    .DATA_WIDTH(32), .DEPTH(4), .NUM_CHANNELS(2), .CLEAR_CYCLES(2)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst), .clear_i(clear_a), .clear_pending_o(pend_a),
    .src_data_i(src_data_a), .src_valid_i(src_valid_a), .src_ready_o(src_ready_a),
    .dst_data_o(dst_data_a), .dst_valid_o(dst_valid_a), .dst_ready_i(dst_ready_a),
    .usage_o(usage_a)
  );

  stream_fifo_clearable_mc #(
    .DATA_WIDTH(32), .DEPTH(3), .NUM_CHANNELS(1), .CLEAR_CYCLES(1)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst), .clear_i(clear_b), .clear_pending_o(pend_b),
    .src_data_i(src_data_b), .src_valid_i(src_valid_b), .src_ready_o(src_ready_b),
    .dst_data_o(dst_data_b), .dst_valid_o(dst_valid_b), .dst_ready_i(dst_ready_b),
    .usage_o(usage_b)
  );

  // Global channel view: 0,1 = instance A, 2 = instance B.
  logic [2:0]  clr_all, sv_all, sr_all, dv_all, dr_all, pend_all;
  logic [31:0] sd_all [3];
  logic [31:0] dd_all [3];
  logic [2:0]  use_all [3];
  assign clr_all = {clear_b, clear_a};
  assign sv_all  = {src_valid_b, src_valid_a};
  assign sr_all  = {src_ready_b, src_ready_a};
  assign dv_all  = {dst_valid_b, dst_valid_a};
  assign dr_all  = {dst_ready_b, dst_ready_a};
  assign pend_all = {pend_b, pend_a};
  assign sd_all[0] = src_data_a[31:0];
  assign sd_all[1] = src_data_a[63:32];
  assign sd_all[2] = src_data_b;
  assign dd_all[0] = dst_data_a[31:0];
  assign dd_all[1] = dst_data_a[63:32];
  assign dd_all[2] = dst_data_b;
  assign use_all[0] = usage_a[2:0];
  assign use_all[1] = usage_a[5:3];
  assign use_all[2] = {1'b0, usage_b};

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  bit saw55 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: a queue per channel plus the number of cycles left in a clear sequence.
  logic [31:0] mq [3][$];
  int clr_left [3] = '{0, 0, 0};
  int m_depth  [3] = '{4, 4, 3};
  int m_cc     [3] = '{2, 2, 1};

  always @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      int sz;
      sz = mq[c].size();
      if (rst) begin
        mq[c].delete();
        clr_left[c] = 0;
      end else if (clr_left[c] > 0) begin
        clr_left[c]--;
        mq[c].delete();
      end else begin
        if (dr_all[c] && sz > 0) void'(mq[c].pop_front());
        if (sv_all[c] && sz < m_depth[c]) mq[c].push_back(sd_all[c]);
        if (clr_all[c]) clr_left[c] = 1 + m_cc[c];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < 3; c++) begin
        bit ep;
        int sz;
        ep = (clr_left[c] > 0);
        sz = mq[c].size();
        check($sformatf("ch%0d pending", c), pend_all[c], ep);
        check($sformatf("ch%0d src_ready", c), sr_all[c], !ep && sz < m_depth[c]);
        check($sformatf("ch%0d dst_valid", c), dv_all[c], !ep && sz > 0);
        if (!ep) check($sformatf("ch%0d usage", c), use_all[c], sz);
        if (!ep && sz > 0) check($sformatf("ch%0d dst_data", c), dd_all[c], mq[c][0]);
      end
      if (dst_valid_a[0] && dst_data_a[31:0] == 32'h55) saw55 = 1'b1;
    end
  end

  for (genvar c = 0; c < 2; c++) begin : g_sva
    a_no_push: assert property (@(posedge clk) disable iff (rst)
      !(src_valid_a[c] && src_ready_a[c] && pend_a[c]));
    a_cnt_max: assert property (@(posedge clk) disable iff (rst) usage_a[c*3 +: 3] <= 3'd4);
    a_val_cnt: assert property (@(posedge clk) disable iff (rst)
      dst_valid_a[c] |-> usage_a[c*3 +: 3] != 3'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  bit exp_pend [9] = '{1, 1, 1, 0, 1, 1, 1, 0, 0};
  int sent, recv;
  logic hs_in, hs_out;

  initial begin
    rst = 1'b1;
    clear_a = '0; src_valid_a = '0; src_data_a = '0; dst_ready_a = '0;
    clear_b = '0; src_valid_b = '0; src_data_b = '0; dst_ready_b = '0;
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset pending", {pend_b, pend_a}, 3'b000);
    check("reset ready", {src_ready_b, src_ready_a}, 3'b111);
    check("reset valid", {dst_valid_b, dst_valid_a}, 3'b000);
    check("reset usage", {usage_b, usage_a}, 8'h00);

    // In-order streaming, one cycle push-to-pop
    src_valid_a[0] = 1'b1; dst_ready_a[0] = 1'b1;
    src_data_a[31:0] = 32'hA1; step();
    check("stream A1", dst_data_a[31:0], 32'hA1);
    check("stream A1 valid", dst_valid_a[0], 1'b1);
    src_data_a[31:0] = 32'hA2; step();
    check("stream A2", dst_data_a[31:0], 32'hA2);
    src_data_a[31:0] = 32'hA3; step();
    check("stream A3", dst_data_a[31:0], 32'hA3);
    src_valid_a[0] = 1'b0; step();
    check("stream usage empty", usage_a[2:0], 3'd0);

    // Full: no pop-through
    dst_ready_a[0] = 1'b0; src_valid_a[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src_data_a[31:0] = 32'hB0 + 32'(i);
      step();
    end
    check("full usage", usage_a[2:0], 3'd4);
    check("full ready", src_ready_a[0], 1'b0);
    src_data_a[31:0] = 32'hB4; step();
    check("full hold usage", usage_a[2:0], 3'd4);
    dst_ready_a[0] = 1'b1; step();
    check("after pop usage", usage_a[2:0], 3'd3);
    check("after pop ready", src_ready_a[0], 1'b1);
    check("after pop head", dst_data_a[31:0], 32'hB1);
    dst_ready_a[0] = 1'b0; step();
    check("fifth accepted", usage_a[2:0], 3'd4);
    src_valid_a[0] = 1'b0; dst_ready_a[0] = 1'b1;
    repeat (4) step();
    check("drain usage", usage_a[2:0], 3'd0);

    // Non-power-of-two wrap on DEPTH=3
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 300 && recv < 10; cyc++) begin
      src_valid_b[0] = (sent < 10);
      src_data_b = 32'hC0 + 32'(sent);
      dst_ready_b[0] = 1'($urandom_range(0, 1));
      hs_in = src_valid_b[0] && src_ready_b[0];
      hs_out = dst_valid_b[0] && dst_ready_b[0];
      if (hs_out) begin
        check("wrap order", dst_data_b, 32'hC0 + 32'(recv));
        recv++;
      end
      step();
      if (hs_in) sent++;
    end
    check("wrap received", recv, 10);
    src_valid_b[0] = 1'b0; dst_ready_b[0] = 1'b0;

    // Clear ch1 with two entries while ch0 streams
    src_valid_a[1] = 1'b1; dst_ready_a[1] = 1'b0;
    src_data_a[63:32] = 32'hD0; step();
    src_data_a[63:32] = 32'hD1; step();
    src_valid_a[1] = 1'b0;
    check("ch1 usage two", usage_a[5:3], 3'd2);
    clear_a[1] = 1'b1;
    src_valid_a[0] = 1'b1; dst_ready_a[0] = 1'b1; src_data_a[31:0] = 32'hE0;
    step();
    clear_a[1] = 1'b0; dst_ready_a[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("ch1 clr pending", pend_a[1], 1'b1);
      check("ch1 clr valid", dst_valid_a[1], 1'b0);
      check("ch1 clr ready", src_ready_a[1], 1'b0);
      src_data_a[31:0] = 32'hE1 + 32'(k);
      step();
    end
    check("ch1 clr done", pend_a[1], 1'b0);
    check("ch1 clr usage", usage_a[5:3], 3'd0);
    check("ch1 no stale", dst_valid_a[1], 1'b0);
    src_valid_a[0] = 1'b0; dst_ready_a[1] = 1'b0;
    step(); step();

    // Handshake coincident with clear is taken then flushed
    src_valid_a[0] = 1'b1; src_data_a[31:0] = 32'h55; clear_a[0] = 1'b1;
    check("55 ready", src_ready_a[0], 1'b1);
    step();
    src_valid_a[0] = 1'b0; clear_a[0] = 1'b0;
    check("55 accepted", usage_a[2:0], 3'd1);
    check("55 pending", pend_a[0], 1'b1);
    repeat (3) step();
    check("55 flushed", usage_a[2:0], 3'd0);
    check("55 idle", pend_a[0], 1'b0);
    check("55 never popped", saw55, 1'b0);

    // Level-held clear restarts the sequence
    clear_a[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 6) clear_a[0] = 1'b0;
      check($sformatf("held clear cycle %0d", k), pend_a[0], exp_pend[k-1]);
    end

    // Reset during FLUSH
    src_valid_a = 2'b11; dst_ready_a = 2'b00;
    src_data_a = {32'hF1, 32'hF0}; step();
    src_valid_a = 2'b00; clear_a[0] = 1'b1; step();
    clear_a[0] = 1'b0; step();
    check("flush pending", pend_a[0], 1'b1);
    rst = 1'b1; src_valid_a = 2'b11; dst_ready_a = 2'b11; step();
    check("rst pending", pend_a, 2'b00);
    check("rst ready", src_ready_a, 2'b11);
    check("rst valid", dst_valid_a, 2'b00);
    check("rst usage", usage_a, 6'd0);
    rst = 1'b0; src_valid_a = 2'b00; dst_ready_a = 2'b00;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
